// File: rtl/pending_encoder_pkg.sv
// Shared constants, state encoding and helpers for the pending encoder.
package pending_encoder_pkg;

    localparam int N = 8;
    localparam int W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // True when exactly one bit of v is set: nonzero and v & (v-1) clears it.
    function automatic logic onehot_count_is_one(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

endpackage

// File: rtl/lsb_prio_enc_8x3.sv
// Combinational priority encoder: index of the lowest set bit, bit 0 highest priority.
import pending_encoder_pkg::*;

module lsb_prio_enc_8x3 (
    input  logic [N-1:0] vec,
    output logic [W-1:0] code,
    output logic         any
);

    always_comb begin
        code = '0;
        any  = |vec;
        // Walk downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                code = W'(i);
            end
        end
    end

endmodule

// File: rtl/pending_encoder_8x3.sv
// Captures a request vector and drains it as binary codes, lowest index first.
// Define PENDING_ENCODER_MERGE_EN to accept and OR new requests while scanning.
import pending_encoder_pkg::*;

module pending_encoder_8x3 (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         req_valid,
    output logic         req_ready,
    output logic [W-1:0] code_out,
    output logic         code_valid,
    input  logic         code_ready,
    output logic         code_last,
    output logic [N-1:0] pending,
    output logic         busy
);

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   pending_next;
    logic [N-1:0]   clear_mask;
    logic [N-1:0]   merge_mask;
    logic [W-1:0]   enc_code;
    logic           enc_any;
    logic           accept;
    logic           handshake;

    lsb_prio_enc_8x3 u_enc (
        .vec  (pending),
        .code (enc_code),
        .any  (enc_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
        end
    end

`ifdef PENDING_ENCODER_MERGE_EN
    assign req_ready = 1'b1;
`else
    assign req_ready = (state == IDLE);
`endif

    assign busy       = (state == SCAN);
    assign code_valid = (state == SCAN) && enc_any;
    assign code_out   = (state == SCAN) ? enc_code : '0;
    assign code_last  = (state == SCAN) && onehot_count_is_one(pending);

    assign accept    = req_valid && req_ready;
    assign handshake = code_valid && code_ready;

    // In the base build acceptance only happens in IDLE where pending is empty,
    // so one update rule covers both capture and merge; set wins over clear.
    always_comb begin
        clear_mask   = '0;
        merge_mask   = '0;
        if (handshake) begin
            clear_mask = N'(1) << enc_code;
        end
        if (accept) begin
            merge_mask = req_in;
        end
        pending_next = (pending & ~clear_mask) | merge_mask;
        state_next   = (pending_next != '0) ? SCAN : IDLE;
    end

endmodule

// File: tb/tb_pending_encoder_8x3.sv
// Directed self-checking bench for pending_encoder_8x3 (base and merge builds).
`timescale 1ns/1ps
module tb_pending_encoder_8x3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] code_out;
    logic       code_valid;
    logic       code_ready;
    logic       code_last;
    logic [7:0] pending;
    logic       busy;

    int checks = 0;
    int errors = 0;

    pending_encoder_8x3 dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_last  (code_last),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        req_in     = 8'h00;
        req_valid  = 1'b0;
        code_ready = 1'b0;

        // Reset
        step(); step();
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_code_valid", 32'(code_valid), 32'd0);
        chk("rst_code_out", 32'(code_out), 32'd0);
        chk("rst_code_last", 32'(code_last), 32'd0);
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);

        // Drain A4 with code_ready held high: 2, 5, 7
        req_in = 8'hA4; req_valid = 1'b1; code_ready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("drain0_valid", 32'(code_valid), 32'd1);
        chk("drain0_code", 32'(code_out), 32'd2);
        chk("drain0_last", 32'(code_last), 32'd0);
        chk("drain0_busy", 32'(busy), 32'd1);
        chk("drain0_pending", 32'(pending), 32'hA4);
`ifndef PENDING_ENCODER_MERGE_EN
        chk("drain0_req_ready", 32'(req_ready), 32'd0);
`endif
        step();
        chk("drain1_code", 32'(code_out), 32'd5);
        chk("drain1_last", 32'(code_last), 32'd0);
        chk("drain1_pending", 32'(pending), 32'hA0);
        step();
        chk("drain2_code", 32'(code_out), 32'd7);
        chk("drain2_last", 32'(code_last), 32'd1);
        step();
        chk("drain_done_valid", 32'(code_valid), 32'd0);
        chk("drain_done_ready", 32'(req_ready), 32'd1);
        chk("drain_done_busy", 32'(busy), 32'd0);
        chk("drain_done_pending", 32'(pending), 32'h00);

        // Backpressure on 81 for 3 cycles
        req_in = 8'h81; req_valid = 1'b1; code_ready = 1'b0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_code", 32'(code_out), 32'd0);
            chk("bp_hold_valid", 32'(code_valid), 32'd1);
            chk("bp_hold_pending", 32'(pending), 32'h81);
            chk("bp_hold_last", 32'(code_last), 32'd0);
            if (i < 2) step();
        end
        code_ready = 1'b1;
        step();
        chk("bp_code7", 32'(code_out), 32'd7);
        chk("bp_last7", 32'(code_last), 32'd1);
        chk("bp_pending80", 32'(pending), 32'h80);
        step();
        chk("bp_done_valid", 32'(code_valid), 32'd0);
        chk("bp_done_ready", 32'(req_ready), 32'd1);

        // Empty request is accepted and dropped
        req_in = 8'h00; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("empty_valid", 32'(code_valid), 32'd0);
        chk("empty_pending", 32'(pending), 32'h00);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of a scan of FF
        req_in = 8'hFF; req_valid = 1'b1; code_ready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("midrst_code0", 32'(code_out), 32'd0);
        step();
        chk("midrst_code1", 32'(code_out), 32'd1);
        chk("midrst_pending", 32'(pending), 32'hFE);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_pending_clr", 32'(pending), 32'h00);
        chk("midrst_valid", 32'(code_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        step();
        chk("midrst_after_valid", 32'(code_valid), 32'd0);
        chk("midrst_after_busy", 32'(busy), 32'd0);

`ifdef PENDING_ENCODER_MERGE_EN
        // Merge 11 into 03 on the cycle code 0 is consumed: 0, 0, 1, 4
        req_in = 8'h03; req_valid = 1'b1; code_ready = 1'b1;
        step();
        chk("merge_code0a", 32'(code_out), 32'd0);
        chk("merge_ready_scan", 32'(req_ready), 32'd1);
        req_in = 8'h11; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("merge_pending", 32'(pending), 32'h13);
        chk("merge_code0b", 32'(code_out), 32'd0);
        step();
        chk("merge_code1", 32'(code_out), 32'd1);
        chk("merge_last1", 32'(code_last), 32'd0);
        step();
        chk("merge_code4", 32'(code_out), 32'd4);
        chk("merge_last4", 32'(code_last), 32'd1);
        step();
        chk("merge_done_valid", 32'(code_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
